axi_lite_read_slave: RTL
========================

Name: axi_lite_read_slave

Overview:
- Responder end of the AXI4-Lite read path; sits opposite the master-side read-address block.
- Accepts one read address per transaction on the AR channel and decodes it against a local bank of 32-bit registers.
- Returns data and response on the R channel after a configurable number of wait cycles.
- Registers are loaded from the local side through a simple write port.

Parameters:
- ADDR_WIDTH, 32, width of ARADDR
- DATA_WIDTH, 32, width of RDATA and the register bank
- NUM_REGS, 8, number of word registers; power of 2, at least 2
- BASE_ADDR, 32'h0000_0000, byte address of register 0; NUM_REGS*4 aligned
- READ_LATENCY, 1, cycles from AR handshake to RVALID; at least 1
- SECURE_ONLY, 0, when 1, non-secure reads (ARPROT[1]=1) get SLVERR

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  reset; synchronous, active-high
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready (registered)
- ARADDR  in  ADDR_WIDTH  read byte address
- ARPROT  in  3  protection attributes
- RVALID  out  1  read data valid (registered)
- RREADY  in  1  read data ready
- RDATA  out  DATA_WIDTH  read data (registered)
- RRESP  out  2  response: 2'b00 OKAY, 2'b10 SLVERR (registered)
- reg_we  in  1  local register write enable
- reg_idx  in  $clog2(NUM_REGS)  local write word index
- reg_wdata  in  DATA_WIDTH  local write data

Behaviour:
- Reset (ARESET high at an edge):
  - ARREADY=0, RVALID=0, RDATA=0, RRESP=2'b00.
  - Counter=0, all registers=0, FSM=IDLE.
  - Applies from any state; a pending response is dropped silently.
- Cycle numbering: "cycle k" is the period after rising edge k.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - ARREADY=1 from the first cycle after ARESET deasserts.
  - If ARVALID&&ARREADY at edge N: capture ARADDR/ARPROT and set ARREADY=0 in cycle N.
  - READ_LATENCY=1: go straight to RESP at edge N.
  - Otherwise: go to WAIT with counter=READ_LATENCY-1.
- WAIT:
  - Counter decrements each edge.
  - At the edge where the counter reaches 0 (edge N+L-1), go to RESP.
- RVALID timing: high from cycle N+L-1.
  - RDATA/RRESP are registered at that same edge.
  - They use register contents as of before that edge; a local write at the same edge is not visible.
- RESP:
  - RVALID, RDATA and RRESP are held stable until RVALID&&RREADY at edge M.
  - In cycle M: RVALID=0, ARREADY=1, FSM=IDLE.
  - RREADY high before RVALID is legal and completes the transfer at the first RVALID edge.
- Throughput: at most one transaction outstanding; minimum L+1 cycles per read. ARVALID outside IDLE is not accepted.
- Decode:
  - off = ARADDR-BASE_ADDR; idx = off[$clog2(NUM_REGS)+1:2].
  - SLVERR if any of: ARADDR<BASE_ADDR; off>=NUM_REGS*4; ARADDR[1:0]!=0; SECURE_ONLY&&ARPROT[1].
  - SLVERR forces RDATA=0.
  - Otherwise RRESP=OKAY and RDATA=reg[idx].
  - ARPROT[0] and ARPROT[2] are ignored.
- Local write: reg_we at an edge writes reg[reg_idx]=reg_wdata in any FSM state. Ignored during ARESET.
- Address arithmetic is ADDR_WIDTH unsigned; no wrap. ARADDR near 2^ADDR_WIDTH with BASE_ADDR=0 yields SLVERR.

Test Plan:
- Reset, then load reg[3]=32'hDEAD_BEEF; AR 32'h0000_000C with L=1, RREADY=1 → RVALID in handshake cycle, RDATA=32'hDEAD_BEEF, RRESP=00, ARREADY back to 1 one cycle later.
- L=4; AR 32'h4, RREADY held 0 for 5 cycles → RVALID rises exactly 3 edges after the handshake edge; RDATA/RRESP stay stable; ARVALID pulses during this time are not accepted.
- AR 32'h0000_0020 (NUM_REGS=8), then AR 32'h0000_0006 → both return SLVERR (2'b10) with RDATA=0.
- SECURE_ONLY=1; AR 32'h0 with ARPROT=3'b010 → SLVERR; ARPROT=3'b000 → OKAY with reg[0].
- ARESET asserted while in RESP with RVALID=1 → next cycle RVALID=0, ARREADY=0, regs=0; after release ARREADY=1 and a new read of reg[0] returns 0.
- Local write to reg[2] at the same edge RVALID rises for a read of reg[2] → RDATA shows the old value; a following read shows the new value.

Source files
------------

// File: rtl/axi_lite_read_slave.sv
// axi_lite_read_slave
//   AXI4-Lite read responder in front of a small bank of 32-bit registers.
//   The local side loads the registers through a simple write port. The AR
//   channel accepts one address per transaction. The R channel returns the
//   decoded word READ_LATENCY cycles after the address handshake.
//
// Ports
//   ACLK, ARESET                     clock, synchronous active-high reset
//   ARVALID/ARREADY/ARADDR/ARPROT    read address channel (ARREADY registered)
//   RVALID/RREADY/RDATA/RRESP        read data channel (outputs registered)
//   reg_we/reg_idx/reg_wdata         local register write port
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ARREADY high, waiting for an address handshake
// WAIT    | address captured, counting down the remaining latency
// RESP    | RVALID high, RDATA/RRESP held until RREADY
module axi_lite_read_slave #(
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    NUM_REGS     = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
   parameter int                    READ_LATENCY = 1,
   parameter int                    SECURE_ONLY  = 0
) (
   input  logic                        ACLK,
   input  logic                        ARESET,
   input  logic                        ARVALID,
   output logic                        ARREADY,
   input  logic [ADDR_WIDTH-1:0]       ARADDR,
   input  logic [2:0]                  ARPROT,
   output logic                        RVALID,
   input  logic                        RREADY,
   output logic [DATA_WIDTH-1:0]       RDATA,
   output logic [1:0]                  RRESP,
   input  logic                        reg_we,
   input  logic [$clog2(NUM_REGS)-1:0] reg_idx,
   input  logic [DATA_WIDTH-1:0]       reg_wdata
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int CNT_W = $clog2(READ_LATENCY + 1);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    nsec_q, nsec_d;
   logic                    arready_q, arready_d;
   logic                    rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

   // Only the non-secure bit of ARPROT affects the response.
   logic unused_prot;
   assign unused_prot = ^{ARPROT[2], ARPROT[0]};

   // With a latency of 1 the response is formed at the handshake edge itself,
   // so decode straight from the bus; otherwise decode the captured address.
   logic [ADDR_WIDTH-1:0]   dec_addr;
   logic                    dec_nsec;
   logic [ADDR_WIDTH-1:0]   dec_off;
   logic [IDX_W-1:0]        dec_idx;
   logic                    dec_err;
   logic [DATA_WIDTH-1:0]   dec_data;
   logic [1:0]              dec_resp;

   always_comb begin
      dec_addr = (state_q == ST_IDLE) ? ARADDR : addr_q;
      dec_nsec = (state_q == ST_IDLE) ? ARPROT[1] : nsec_q;
      dec_off  = dec_addr - BASE_ADDR;
      dec_idx  = dec_off[IDX_W+1:2];
      // The below-base test guards against the subtraction wrapping into range.
      dec_err  = (dec_addr < BASE_ADDR)
              || (dec_off >= ADDR_WIDTH'(NUM_REGS * 4))
              || (dec_addr[1:0] != 2'b00)
              || ((SECURE_ONLY != 0) && dec_nsec);
      dec_data = dec_err ? '0 : regs_q[dec_idx];
      dec_resp = dec_err ? RESP_SLVERR : RESP_OKAY;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      nsec_d    = nsec_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (state_q)
         ST_IDLE: begin
            arready_d = 1'b1;
            if (ARVALID && arready_q) begin
               arready_d = 1'b0;
               addr_d    = ARADDR;
               nsec_d    = ARPROT[1];
               if (READ_LATENCY == 1) begin
                  state_d  = ST_RESP;
                  rvalid_d = 1'b1;
                  rdata_d  = dec_data;
                  rresp_d  = dec_resp;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_W'(READ_LATENCY - 1);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == CNT_W'(1)) begin
               cnt_d    = '0;
               state_d  = ST_RESP;
               rvalid_d = 1'b1;
               rdata_d  = dec_data;
               rresp_d  = dec_resp;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (RREADY) begin
               state_d   = ST_IDLE;
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         nsec_q    <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         nsec_q    <= nsec_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (reg_we) begin
         regs_q[reg_idx] <= reg_wdata;
      end
   end

   assign ARREADY = arready_q;
   assign RVALID  = rvalid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;

endmodule
